// File: rtl/multiplier_pkg.sv
// Shared constants and FSM encoding for the sequential shift-add multiplier.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package multiplier_pkg;

  // Default operand widths: multiplicand N bits, multiplier M bits (M = iteration count).
  localparam int DEFAULT_N = 8;
  localparam int DEFAULT_M = 4;

  // Controller states: waiting for operands, iterating over multiplier bits, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : multiplier_pkg

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: o_result_valid pulses M+1 cycles after the accept edge; one op per M+2 cycles.
// Backpressure: o_mult_ready is low while busy; i_data_valid is ignored until it returns high.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int M = DEFAULT_M
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_data_valid,
  input  logic [N-1:0]   i_mult1,
  input  logic [M-1:0]   i_mult2,
  output logic [N+M-1:0] o_result,
  output logic           o_result_valid,
  output logic           o_mult_ready
);

  localparam int W     = N + M;
  // One spare bit so the counter can represent M itself without wrapping.
  localparam int CNT_W = $clog2(M) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Multiplicand is kept pre-widened and shifted left each cycle, so bit k of the
  // multiplier always lines up with the multiplicand shifted by k.
  logic [W-1:0]     mcand_q, mcand_d;
  // Multiplier shifts right each cycle; bit 0 is always the bit under consideration.
  logic [M-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     result_d;
  logic             valid_d;
  logic             ready_d;
  logic [W-1:0]     addend;
  logic [W-1:0]     sum;

  // Single accumulator adder: add the aligned multiplicand only when the current bit is set.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = acc_q + addend;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = o_result;
    valid_d  = 1'b0;
    ready_d  = o_mult_ready;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (i_data_valid && o_mult_ready) begin
          mcand_d  = {{M{1'b0}}, i_mult1};
          mplier_d = i_mult2;
          acc_d    = '0;
          cnt_d    = '0;
          ready_d  = 1'b0;
          state_d  = CALC;
        end
      end

      CALC: begin
        ready_d  = 1'b0;
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last bit processed: publish the product directly from the adder output.
        if (cnt_q == LAST_CNT) begin
          result_d = sum;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        // Ready rises on the way back to IDLE, so DONE itself still reports busy.
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_mult_ready   <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      o_result       <= result_d;
      o_result_valid <= valid_d;
      o_mult_ready   <= ready_d;
    end
  end

endmodule : multiplier

// File: tb/tb_multiplier.sv
// Self-checking bench for the sequential multiplier using an expected-result queue.
// Latency: results are expected exactly M+1 cycles after each accept edge.
// Backpressure: operands are only offered when o_mult_ready is observed high.
module tb_multiplier;
  import multiplier_pkg::*;

  localparam int N = DEFAULT_N;
  localparam int M = DEFAULT_M;
  localparam int W = N + M;

  logic           i_clk        = 1'b0;
  logic           i_rst        = 1'b1;
  logic           i_data_valid = 1'b0;
  logic [N-1:0]   i_mult1      = '0;
  logic [M-1:0]   i_mult2      = '0;
  logic [W-1:0]   o_result;
  logic           o_result_valid;
  logic           o_mult_ready;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  logic [W-1:0] exp_q[$];
  int           acc_t_q[$];
  logic [W-1:0] last_exp = '0;
  logic         mon_en   = 1'b0;
  logic         prev_vld = 1'b0;

  multiplier #(.N(N), .M(M)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_data_valid   (i_data_valid),
    .i_mult1        (i_mult1),
    .i_mult2        (i_mult2),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_mult_ready   (o_mult_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) ncyc <= ncyc + 1;

  // Output monitor: readiness, pulse shape, latency, result value and result hold.
  always @(negedge i_clk) begin
    if (mon_en) begin
      checks++;
      if (o_mult_ready !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL ready_state: got %0b expected %0b at cycle %0d",
                 o_mult_ready, (exp_q.size() == 0), ncyc);
      end
      if (o_result_valid === 1'b1) begin
        checks++;
        if (prev_vld) begin
          errors++;
          $display("FAIL valid_pulse_width: valid high for two cycles at cycle %0d", ncyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got result %0d with nothing outstanding at cycle %0d",
                   o_result, ncyc);
        end else begin
          logic [W-1:0] e;
          int           t;
          e = exp_q.pop_front();
          t = acc_t_q.pop_front();
          if (o_result !== e) begin
            errors++;
            $display("FAIL result_value: got %0d expected %0d", o_result, e);
          end
          checks++;
          if (ncyc !== t + M + 1) begin
            errors++;
            $display("FAIL result_latency: got %0d cycles expected %0d", ncyc - t, M + 1);
          end
          last_exp = e;
        end
      end else begin
        checks++;
        if (o_result_valid !== 1'b0 || o_result !== last_exp) begin
          errors++;
          $display("FAIL result_hold: got valid %0b result %0d expected valid 0 result %0d",
                   o_result_valid, o_result, last_exp);
        end
      end
      prev_vld = (o_result_valid === 1'b1);
    end
  end

  // Offer one operand pair when ready; entered and left at a negedge.
  task automatic send(input logic [N-1:0] a, input logic [M-1:0] b);
    int n;
    int t;
    n = 0;
    while (o_mult_ready !== 1'b1 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (o_mult_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: got ready %0b expected 1 within 50 cycles", o_mult_ready);
    end
    i_data_valid = 1'b1;
    i_mult1      = a;
    i_mult2      = b;
    t            = ncyc;
    @(posedge i_clk);
    exp_q.push_back(W'(a) * W'(b));
    acc_t_q.push_back(t);
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    // Operands presented during reset must be ignored.
    i_data_valid = 1'b1;
    i_mult1      = 8'd7;
    i_mult2      = 4'd3;
    @(negedge i_clk);
    mon_en = 1'b1;
    repeat (4) @(negedge i_clk);
    i_rst        = 1'b0;
    i_data_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_mult_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b expected 1", o_mult_ready);
    end
    checks++;
    if (o_result !== '0) begin
      errors++;
      $display("FAIL reset_result: got %0d expected 0", o_result);
    end
    checks++;
    if (o_result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b expected 0", o_result_valid);
    end
  endtask

  task automatic test_sequential();
    logic [N-1:0] a_tab [5] = '{8'd25, 8'd16, 8'd10, 8'd15, 8'd215};
    logic [M-1:0] b_tab [5] = '{4'd5, 4'd10, 4'd4, 4'd7, 4'd9};
    for (int i = 0; i < 5; i++) send(a_tab[i], b_tab[i]);
    wait_drain();
  endtask

  task automatic test_boundary();
    send(8'd255, 4'd15);
    send(8'd0, 4'd15);
    send(8'd255, 4'd0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n;
    int last_t;
    int n_acc;
    logic rdy;
    int t;
    n = 0;
    while (o_mult_ready !== 1'b1 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    last_t = -1;
    n_acc  = 0;
    for (int k = 0; k < 3 * (M + 2); k++) begin
      i_data_valid = 1'b1;
      i_mult1      = N'($urandom);
      i_mult2      = M'($urandom);
      rdy          = o_mult_ready;
      t            = ncyc;
      @(posedge i_clk);
      if (rdy) begin
        exp_q.push_back(W'(i_mult1) * W'(i_mult2));
        acc_t_q.push_back(t);
        if (last_t >= 0) begin
          checks++;
          if (t - last_t != M + 2) begin
            errors++;
            $display("FAIL throughput: got %0d cycles between accepts expected %0d",
                     t - last_t, M + 2);
          end
        end
        last_t = t;
        n_acc++;
      end
      @(negedge i_clk);
    end
    i_data_valid = 1'b0;
    checks++;
    if (n_acc != 3) begin
      errors++;
      $display("FAIL accept_count: got %0d expected 3", n_acc);
    end
    wait_drain();
  endtask

  task automatic test_reset_abort();
    send(8'd215, 4'd9);
    @(negedge i_clk);
    checks++;
    if (o_mult_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: got %0b expected 0", o_mult_ready);
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    exp_q.delete();
    acc_t_q.delete();
    last_exp = '0;
    prev_vld = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_result_valid !== 1'b0 || o_result !== '0 || o_mult_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs: got valid %0b result %0d ready %0b expected 0 0 1",
               o_result_valid, o_result, o_mult_ready);
    end
    i_rst = 1'b0;
    send(8'd16, 4'd10);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule : tb_multiplier

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have parameter N, default 8, width of multiplicand i_mult1 (N >= 2).
REQ-002 SHALL have parameter M, default 4, width of multiplier i_mult2 and number of iteration cycles (M >= 2).
REQ-003 SHALL have port i_clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port i_data_valid  input  1  operand-valid strobe.
REQ-006 SHALL have port i_mult1  input  N  unsigned multiplicand.
REQ-007 SHALL have port i_mult2  input  M  unsigned multiplier.
REQ-008 SHALL have port o_result  output  N+M  unsigned product i_mult1*i_mult2.
REQ-009 SHALL have port o_result_valid  output  1  one-cycle pulse marking o_result valid.
REQ-010 SHALL have port o_mult_ready  output  1  high when a new operand pair can be accepted.

Function
REQ-011 SHALL implement sequential unsigned shift-add multiplication, one bit of i_mult2 per cycle, LSB first.
REQ-012 SHALL use FSM states IDLE, CALC, DONE; registered outputs only.
REQ-013 IDLE: o_mult_ready=1; accept occurs on the rising edge where i_data_valid=1 and o_mult_ready=1; operands latched; go to CALC.
REQ-014 i_data_valid while o_mult_ready=0 SHALL be ignored; operands are not re-sampled mid-operation.
REQ-015 CALC SHALL last exactly M cycles: if the current multiplier bit is 1, add the multiplicand shifted by the bit index into an N+M-bit accumulator; then go to DONE.
REQ-016 DONE SHALL last one cycle: o_result=final product, o_result_valid=1, o_mult_ready=0; next state IDLE.
REQ-017 Latency: o_result_valid SHALL be high in the (M+1)th cycle after the accept edge; back-to-back throughput is one operation per M+2 cycles.
REQ-018 o_result SHALL hold the last product until the next DONE; the accumulator SHALL clear on each accept.
REQ-019 Product SHALL never overflow: max (2^N-1)(2^M-1) fits in N+M bits; no truncation or saturation.
REQ-020 Zero operands SHALL still take the full M-cycle CALC and return 0.
REQ-021 o_mult_ready SHALL be 0 in CALC and DONE, and 1 in IDLE.

Reset
REQ-022 On i_rst=1 at a clock edge: state=IDLE, o_result=0, o_result_valid=0, o_mult_ready=1, accumulator, counter and operand registers=0.
REQ-023 Reset asserted mid-operation SHALL abort without any o_result_valid pulse; the first accept is possible on the first edge after i_rst deasserts.
REQ-024 The inputs i_data_valid, i_mult1 and i_mult2 SHALL be ignored while i_rst=1.

Structure
REQ-025 A shared package SHALL hold the default N/M constants and the FSM state typedef (IDLE, CALC, DONE).
REQ-026 The block SHALL be a single module without sub-modules; the iteration counter SHALL be clog2(M)+1 bits wide.
REQ-027 The RTL SHALL be synthesizable and free of latches; the arithmetic SHALL be at most one N+M-bit adder per cycle, with no inferred full multiplier.

Verification
REQ-028 Reset for 5 cycles, then release -> o_mult_ready=1, o_result=0, o_result_valid=0.
REQ-029 Sequential pairs 25x5, 16x10, 10x4, 15x7, 215x9, each sent only when ready -> results 125, 160, 40, 105, 1935, each as a single-cycle valid pulse M+1 cycles after accept.
REQ-030 Boundary 255x15 -> 3825; 0x15 -> 0; 255x0 -> 0; all with full latency.
REQ-031 Hold i_data_valid=1 continuously with changing operands -> only the values present at each accept edge are used; one result per M+2 cycles.
REQ-032 Assert i_rst during CALC of 215x9 -> no valid pulse, outputs return to reset values; a following 16x10 -> 160.
